// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU (EXE stage).
// Optional last-result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic            r_q_neg;
  logic            r_r_neg;
  logic            r_sel_rem;

  logic            w_accept;
  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div0;
  logic            w_ovf;
  logic            w_hit;
  logic            w_fast;
  logic [XLEN-1:0] w_spec_res;
  logic [XLEN-1:0] w_hit_res;
  logic [XLEN-1:0] w_fast_res;
  logic            w_last;
  logic [XLEN:0]   w_shift;
  logic            w_qbit;
  logic [XLEN-1:0] w_sub;
  logic [XLEN-1:0] w_q_next;
  logic [XLEN-1:0] w_r_next;
  logic [XLEN-1:0] w_q_fin;
  logic [XLEN-1:0] w_r_fin;

  assign w_accept = start & ~flush & ~reset & (r_state != S_CALC);
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & dividend[XLEN-1];
  assign w_b_neg  = w_signed & divisor[XLEN-1];
  // Modulo-2^XLEN negation of the most negative value yields its unsigned magnitude.
  assign w_a_mag  = w_a_neg ? ('0 - dividend) : dividend;
  assign w_b_mag  = w_b_neg ? ('0 - divisor)  : divisor;

  assign w_div0     = (divisor == '0);
  assign w_ovf      = w_signed & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (divisor == '1);
  assign w_spec_res = w_div0 ? (op[1] ? dividend : '1) : (op[1] ? '0 : dividend);
  assign w_fast     = w_div0 | w_ovf | w_hit;
  assign w_fast_res = (w_div0 | w_ovf) ? w_spec_res : w_hit_res;

  // One restoring step: the shifted remainder is XLEN+1 bits, so compare before subtracting.
  assign w_last   = (r_state == S_CALC) && (r_cnt == CW'(XLEN - 1));
  assign w_shift  = {r_rem, r_quo[XLEN-1]};
  assign w_qbit   = (w_shift >= {1'b0, r_dvs});
  assign w_sub    = w_shift[XLEN-1:0] - r_dvs;
  assign w_q_next = {r_quo[XLEN-2:0], w_qbit};
  assign w_r_next = w_qbit ? w_sub : w_shift[XLEN-1:0];
  assign w_q_fin  = r_q_neg ? ('0 - w_q_next) : w_q_next;
  assign w_r_fin  = r_r_neg ? ('0 - w_r_next) : w_r_next;

  assign busy = (r_state == S_CALC) | w_accept;
  assign done = (r_state == S_DONE);

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) w_next = w_fast ? S_DONE : S_CALC;
          else          w_next = S_IDLE;
        end
        S_CALC:  if (w_last) w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_sel_rem <= 1'b0;
      result    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt     <= '0;
        r_rem     <= '0;
        r_quo     <= w_a_mag;
        r_dvs     <= w_b_mag;
        r_q_neg   <= w_a_neg ^ w_b_neg;
        r_r_neg   <= w_a_neg;
        r_sel_rem <= op[1];
        if (w_fast) result <= w_fast_res;
      end else if ((r_state == S_CALC) && !flush) begin
        r_cnt <= r_cnt + CW'(1);
        r_rem <= w_r_next;
        r_quo <= w_q_next;
        if (w_last) result <= r_sel_rem ? w_r_fin : w_q_fin;
      end
    end
  end

`ifdef DIV_RESULT_CACHE_EN
  logic            r_c_valid;
  logic [XLEN-1:0] r_c_dvd;
  logic [XLEN-1:0] r_c_dvs;
  logic            r_c_uns;
  logic [XLEN-1:0] r_c_quo;
  logic [XLEN-1:0] r_c_rem;
  logic [XLEN-1:0] r_op_dvd;
  logic [XLEN-1:0] r_op_dvs;
  logic            r_op_uns;

  assign w_hit     = r_c_valid & (dividend == r_c_dvd) & (divisor == r_c_dvs) & (op[0] == r_c_uns);
  assign w_hit_res = op[1] ? r_c_rem : r_c_quo;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_c_valid <= 1'b0;
      r_c_dvd   <= '0;
      r_c_dvs   <= '0;
      r_c_uns   <= 1'b0;
      r_c_quo   <= '0;
      r_c_rem   <= '0;
      r_op_dvd  <= '0;
      r_op_dvs  <= '0;
      r_op_uns  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_dvd <= dividend;
        r_op_dvs <= divisor;
        r_op_uns <= op[0];
      end
      if (w_last && !flush) begin
        r_c_valid <= 1'b1;
        r_c_dvd   <= r_op_dvd;
        r_c_dvs   <= r_op_dvs;
        r_c_uns   <= r_op_uns;
        r_c_quo   <= w_q_fin;
        r_c_rem   <= w_r_fin;
      end
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_hit_res = '0;
`endif

endmodule
